// File: rtl/dmem_arbiter.sv
// Arbitrates the RAM data port between the CPU MEM stage and the loader/debug port,
// and routes the one-cycle-latency read data back to whichever side issued the read.
module dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [3:0]        ldr_be,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [31:0]       ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic [ADDR_W-1:0] d_addr,
    output logic              d_we,
    output logic [3:0]        d_be,
    output logic [31:0]       d_wdata,
    input  logic [31:0]       d_rdata
);

    typedef enum logic {ARB, LOCKED} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       rd_pend;
    logic       rd_own;

    always_comb begin
        cpu_gnt   = 1'b0;
        ldr_gnt   = 1'b0;
        state_nxt = state;
        if (!rst) begin
            case (state)
                ARB: begin
                    ldr_gnt = ldr_req & (~cpu_req | (wait_cnt == WAIT_MAX));
                    cpu_gnt = cpu_req & ~ldr_gnt;
                    if (ldr_gnt & ldr_lock)
                        state_nxt = LOCKED;
                end
                LOCKED: begin
                    // The cycle the lock drops still belongs to the loader.
                    ldr_gnt = ldr_req;
                    if (!ldr_lock)
                        state_nxt = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    always_comb begin
        d_we    = 1'b0;
        d_addr  = cpu_addr;
        d_be    = cpu_be;
        d_wdata = cpu_wdata;
        if (ldr_gnt) begin
            d_we    = ldr_we;
            d_addr  = ldr_addr;
            d_be    = ldr_be;
            d_wdata = ldr_wdata;
        end else if (cpu_gnt) begin
            d_we = cpu_we;
        end
    end

    // Grant cycle -> read-return cycle boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            wait_cnt <= 4'd0;
            rd_pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ldr_req & ~ldr_gnt)
                wait_cnt <= (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
            rd_pend <= (cpu_gnt & ~cpu_we) | (ldr_gnt & ~ldr_we);
        end
    end

    always_ff @(posedge clk) begin
        rd_own <= ldr_gnt;
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rvalid = ~rst & rd_pend & ~rd_own;
    assign ldr_rvalid = ~rst & rd_pend & rd_own;
    assign cpu_rdata  = d_rdata;
    assign ldr_rdata  = d_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a RAM with registered reads, a rule-level arbitration
// model checked every cycle, and literal expectations for the key scenarios.
module tb_dmem_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int ADDR_W   = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we;
    logic [3:0]        cpu_be;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0]       cpu_rdata;
    logic              ldr_req, ldr_we, ldr_lock;
    logic [3:0]        ldr_be;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_gnt, ldr_rvalid;
    logic [31:0]       ldr_rdata;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_wdata;
    logic [31:0]       d_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt),
        .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .d_addr(d_addr), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM: writes on d_we, otherwise registered read; d_rdata holds on writes.
    always @(posedge clk) begin
        if (d_we) ram[d_addr[7:0]] <= merge(ram[d_addr[7:0]], d_wdata, d_be);
        else      d_rdata <= ram[d_addr[7:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Rule-level model: denial streak, exclusive flag, pending read owner/data.
    int          m_streak = 0;
    bit          m_excl   = 0;
    int          m_pend   = -1;
    logic [31:0] m_pdata;
    bit          m_ec, m_el;

    always @(negedge clk) begin
        if (rst)         begin m_ec = 0; m_el = 0; end
        else if (m_excl) begin m_ec = 0; m_el = ldr_req; end
        else begin
            m_el = ldr_req && (!cpu_req || m_streak == MAX_WAIT);
            m_ec = cpu_req && !m_el;
        end
        chk("m_cpu_gnt", 64'(cpu_gnt), 64'(m_ec));
        chk("m_ldr_gnt", 64'(ldr_gnt), 64'(m_el));
        chk("m_cpu_stall", 64'(cpu_stall), 64'(cpu_req && !m_ec));
        chk("m_d_we", 64'(d_we), 64'((m_ec && cpu_we) || (m_el && ldr_we)));
        if (m_ec) begin
            chk("m_d_addr_cpu", 64'(d_addr), 64'(cpu_addr));
            if (cpu_we) chk("m_d_wr_cpu", {28'd0, d_be, d_wdata}, {28'd0, cpu_be, cpu_wdata});
        end
        if (m_el) begin
            chk("m_d_addr_ldr", 64'(d_addr), 64'(ldr_addr));
            if (ldr_we) chk("m_d_wr_ldr", {28'd0, d_be, d_wdata}, {28'd0, ldr_be, ldr_wdata});
        end
        chk("m_cpu_rvalid", 64'(cpu_rvalid), 64'(!rst && m_pend == 0));
        chk("m_ldr_rvalid", 64'(ldr_rvalid), 64'(!rst && m_pend == 1));
        if (!rst && m_pend == 0) chk("m_cpu_rdata", 64'(cpu_rdata), 64'(m_pdata));
        if (!rst && m_pend == 1) chk("m_ldr_rdata", 64'(ldr_rdata), 64'(m_pdata));

        if (rst) begin
            m_streak = 0; m_excl = 0; m_pend = -1;
        end else begin
            if (ldr_req && !m_el) m_streak = (m_streak < MAX_WAIT) ? m_streak + 1 : MAX_WAIT;
            else                  m_streak = 0;
            m_excl = m_excl ? ldr_lock : (m_el && ldr_lock);
            m_pend = -1;
            if (m_ec) begin
                if (cpu_we) ref_mem[cpu_addr[7:0]] = merge(ref_mem[cpu_addr[7:0]], cpu_wdata, cpu_be);
                else begin m_pend = 0; m_pdata = ref_mem[cpu_addr[7:0]]; end
            end
            if (m_el) begin
                if (ldr_we) ref_mem[ldr_addr[7:0]] = merge(ref_mem[ldr_addr[7:0]], ldr_wdata, ldr_be);
                else begin m_pend = 1; m_pdata = ref_mem[ldr_addr[7:0]]; end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_be = 4'h0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
    endtask

    task automatic cpu_op(input logic we, input logic [3:0] be, input logic [7:0] a,
                          input logic [31:0] wd);
        cpu_req = 1; cpu_we = we; cpu_be = be; cpu_addr = ADDR_W'(a); cpu_wdata = wd;
    endtask

    task automatic ldr_op(input logic we, input logic [3:0] be, input logic [7:0] a,
                          input logic [31:0] wd, input logic lock);
        ldr_req = 1; ldr_we = we; ldr_be = be; ldr_addr = ADDR_W'(a); ldr_wdata = wd;
        ldr_lock = lock;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h5A5A_0000 + 32'(i);
            ref_mem[i] = 32'h5A5A_0000 + 32'(i);
        end
        idle();
        rst = 1;
        cpu_op(0, 4'h0, 8'h01, 32'h0);
        ldr_op(0, 4'h0, 8'h02, 32'h0, 0);

        // Reset with both requesting.
        for (int c = 0; c < 2; c++) begin
            smp();
            chk("rst_gnts", {62'd0, cpu_gnt, ldr_gnt}, 64'd0);
            chk("rst_d_we", 64'(d_we), 64'd0);
            chk("rst_rvalid", {62'd0, cpu_rvalid, ldr_rvalid}, 64'd0);
            chk("rst_stall", 64'(cpu_stall), 64'd1);
            nxt();
        end
        rst = 0;
        smp();
        chk("post_rst_cpu_gnt", 64'(cpu_gnt), 64'd1);
        chk("post_rst_ldr_gnt", 64'(ldr_gnt), 64'd0);
        nxt(); idle(); smp(); nxt(); smp(); nxt();

        // CPU store then load.
        cpu_op(1, 4'b0011, 8'h10, 32'hAABBCCDD);
        smp();
        chk("st_gnt_we", {62'd0, cpu_gnt, d_we}, 64'd3);
        nxt();
        cpu_op(0, 4'h0, 8'h10, 32'h0);
        smp();
        chk("ld_gnt", 64'(cpu_gnt), 64'd1);
        chk("ld_no_early_rvalid", 64'(cpu_rvalid), 64'd0);
        nxt(); idle(); smp();
        chk("ld_rvalid", {62'd0, cpu_rvalid, ldr_rvalid}, 64'd2);
        chk("ld_rdata", 64'(cpu_rdata), 64'h5A5ACCDD);
        nxt(); smp();
        chk("ld_rvalid_once", 64'(cpu_rvalid), 64'd0);
        nxt();

        // Starvation: both requesting for 10 cycles.
        for (int k = 1; k <= 10; k++) begin
            cpu_op(0, 4'h0, 8'(k), 32'h0);
            ldr_op(0, 4'h0, 8'(8'h40 + k), 32'h0, 0);
            smp();
            chk("starve_ldr_gnt", 64'(ldr_gnt), 64'(k == 5 || k == 10));
            chk("starve_stall", 64'(cpu_stall), 64'(k == 5 || k == 10));
            nxt();
        end
        idle(); smp(); nxt();

        // Lock: loader enters exclusive ownership, then writes three more words.
        ldr_op(1, 4'hF, 8'h30, 32'h1111_0000, 1);
        smp();
        chk("lock_first_gnt", 64'(ldr_gnt), 64'd1);
        nxt();
        cpu_op(0, 4'h0, 8'h05, 32'h0);
        for (int j = 1; j <= 3; j++) begin
            ldr_op(1, 4'hF, 8'(8'h30 + j), 32'h1111_0000 + 32'(j), 1);
            smp();
            chk("lock_cpu_blocked", {62'd0, cpu_gnt, ldr_gnt}, 64'd1);
            nxt();
        end
        ldr_req = 0; ldr_lock = 0;
        smp();
        chk("unlock_cycle_cpu_gnt", {62'd0, cpu_gnt, cpu_stall}, 64'd1);
        nxt(); smp();
        chk("after_unlock_cpu_gnt", 64'(cpu_gnt), 64'd1);
        nxt(); idle(); smp(); nxt();

        // Interleaved reads with alternating owners.
        cpu_op(0, 4'h0, 8'h20, 32'h0);
        smp(); nxt();
        idle();
        ldr_op(0, 4'h0, 8'h24, 32'h0, 0);
        smp();
        chk("il_cpu_rvalid", {62'd0, cpu_rvalid, ldr_rvalid}, 64'd2);
        chk("il_cpu_rdata", 64'(cpu_rdata), 64'h5A5A0020);
        chk("il_ldr_gnt", 64'(ldr_gnt), 64'd1);
        nxt(); idle(); smp();
        chk("il_ldr_rvalid", {62'd0, cpu_rvalid, ldr_rvalid}, 64'd1);
        chk("il_ldr_rdata", 64'(ldr_rdata), 64'h5A5A0024);
        nxt();

        // Reset mid-read while locked.
        ldr_op(0, 4'h0, 8'h24, 32'h0, 1);
        smp();
        chk("mr_ldr_gnt", 64'(ldr_gnt), 64'd1);
        nxt();
        ldr_req = 0;
        rst = 1;
        smp();
        chk("mr_rst_rvalid", 64'(ldr_rvalid), 64'd0);
        nxt();
        rst = 0;
        cpu_op(0, 4'h0, 8'h07, 32'h0);
        smp();
        chk("mr_after_rvalid", 64'(ldr_rvalid), 64'd0);
        chk("mr_lock_abandoned", 64'(cpu_gnt), 64'd1);
        nxt(); idle(); smp(); nxt(); smp();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter for the data port of the instruction/data dual-port RAM. The CPU MEM stage and a memory loader/debug port share the port; the block grants one access per cycle and routes the one-cycle-latency read data back to its owner. The CPU wins by default, while a starvation counter and a loader lock guarantee loader progress. It sits between the pipeline's MEM stage and the RAM data port. The RAM instruction port is untouched.

## Interface
- MAX_WAIT, 4, consecutive cycles the loader may be denied before it takes priority (1..15)
- ADDR_W, 30, word-address width (byte address bits 31:2)
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = store, 0 = load
- cpu_be  in  4  byte enables for stores
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  store data
- cpu_gnt  out  1  access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt (drives pipeline hold)
- cpu_rvalid  out  1  load data valid on cpu_rdata
- cpu_rdata  out  32  load data
- ldr_req, ldr_we, ldr_be, ldr_addr, ldr_wdata  in  1/1/4/ADDR_W/32  loader request, same meaning as the cpu_* inputs
- ldr_lock  in  1  loader requests exclusive ownership while asserted
- ldr_gnt, ldr_rvalid  out  1  loader grant and read-valid
- ldr_rdata  out  32  loader read data
- d_addr  out  ADDR_W  RAM data-port address
- d_we  out  1  RAM write enable
- d_be  out  4  RAM byte enables
- d_wdata  out  32  RAM write data
- d_rdata  in  32  RAM registered read data, valid the cycle after a read

## Operation
- FSM states:
  - ARB: normal arbitration.
  - LOCKED: loader-exclusive.
- ARB grant rule:
  - Loader is granted if ldr_req and (~cpu_req or wait_cnt == MAX_WAIT).
  - Otherwise the CPU is granted if cpu_req.
  - At most one grant per cycle.
- LOCKED grant rule: cpu_gnt = 0 always; ldr_gnt = ldr_req.
- Transitions, evaluated at the clock edge:
  - ARB→LOCKED when ldr_gnt & ldr_lock.
  - LOCKED→ARB when ldr_lock = 0.
  - The cycle in which ldr_lock drops while in LOCKED still blocks the CPU.
- Grants and RAM outputs are combinational from the current inputs and state.
  - d_addr/d_be/d_wdata mux from the granted requester.
  - d_we = granted requester's we.
  - With no grant: d_we = 0 and the other RAM outputs are don't-care. The bench must check only that d_we = 0.
- wait_cnt (width 4, saturating at MAX_WAIT):
  - Increments each cycle ldr_req & ~ldr_gnt.
  - Clears to 0 when ldr_gnt or ~ldr_req.
- Read tracking:
  - A granted read (we = 0) sets rd_pend = 1 and records rd_own (0 = CPU, 1 = loader) at the edge. Otherwise rd_pend = 0.
  - The next cycle, the owner's rvalid = rd_pend, and the owner's rdata = d_rdata. The other requester's rvalid = 0.
  - rdata outputs are d_rdata unconditionally; consumers must qualify with rvalid.
- Writes never produce rvalid. The RAM does not update d_rdata on writes.
- Back-to-back reads, including alternating owners, are fully pipelined at one per cycle.

## Timing
- Grant latency is 0 cycles, same cycle as the request when it wins.
- Read data latency: exactly 1 cycle after the grant cycle.
- Reset, synchronous:
  - State = ARB, wait_cnt = 0, rd_pend = 0.
  - While rst = 1: cpu_gnt, ldr_gnt, d_we, cpu_rvalid, ldr_rvalid = 0, and cpu_stall = cpu_req.
- Reset mid-operation: a read granted the cycle before reset produces no rvalid afterward, and a LOCKED state is abandoned.
- Simultaneous cpu_req & ldr_req with wait_cnt < MAX_WAIT: CPU wins and wait_cnt increments.
- wait_cnt == MAX_WAIT: the loader wins that cycle, the counter clears, and the CPU stalls exactly one cycle.
- Loader continuously requesting against a continuous CPU: the loader gets 1 grant per MAX_WAIT+1 cycles.

## Test plan
- Reset with both requests high: rst = 1 for 2 cycles → all grants, rvalids and d_we = 0; cpu_stall = 1. First cycle after reset → cpu_gnt = 1.
- CPU store then load: store be = 4'b0011, addr 0x10, data 0xAABBCCDD, then load 0x10 → the RAM word's low half = 0xCCDD; cpu_rvalid = 1 exactly one cycle after the load grant; ldr_rvalid stays 0.
- Starvation with MAX_WAIT = 4: cpu_req and ldr_req held high for 10 cycles →
  - ldr_gnt in cycles 5 and 10 only;
  - cpu_stall high in exactly those cycles.
- Lock, with loader alone:
  - Loader is granted with ldr_lock = 1, then 3 more loader writes; cpu_req is high throughout → cpu_gnt = 0 for all those cycles.
  - ldr_lock is then dropped → cpu_gnt = 0 that cycle and 1 the following cycle.
- Interleaved reads: CPU read 0x20 in cycle n, loader read 0x24 in cycle n+1 (CPU idle) → cpu_rvalid at n+1 with mem[0x20], ldr_rvalid at n+2 with mem[0x24].
- Reset mid-read: loader read granted, rst asserted the next cycle → ldr_rvalid stays 0.
